// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: channel mode encodings shared by the LED pattern generator.
package led_pattern_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;
endpackage

// File: rtl/led_pattern_chan.sv
// led_pattern_chan: one LED channel's config, period counter, blink state and lit decode.
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             lit,
  output logic             period_tick
);
  mode_t            mode;
  logic [CNT_W-1:0] period, duty, cnt;
  logic             blink, at_last;
  // a zero period behaves as one tick per period
  assign at_last = cnt == ((period == '0) ? '0 : period - 1'b1);
  assign lit = (mode == MODE_ON) | ((mode == MODE_BLINK) & blink) | ((mode == MODE_PWM) & (cnt < duty));
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= MODE_OFF;
      period      <= CNT_W'(1);
      duty        <= '0;
      cnt         <= '0;
      blink       <= 1'b0;
      period_tick <= 1'b0;
    end else if (wr) begin
      mode        <= wr_mode;
      period      <= wr_period;
      duty        <= wr_duty;
      cnt         <= '0;
      blink       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= tick & at_last;
      if (tick) begin
        cnt   <= at_last ? '0 : cnt + 1'b1;
        blink <= blink ^ at_last;
      end
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with shared prescaler, config port and pin polarity.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int CNT_W      = 26,
  parameter int PRESCALE   = 1,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] period_tick,
  output logic [NUM_CH-1:0] led_out
);
  localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{ACTIVE_LOW}};
  logic [PS_W-1:0]   ps_cnt;
  logic [NUM_CH-1:0] lit;
  logic              tick, accept, ch_ok;
  assign tick   = ps_cnt == PS_W'(PRESCALE - 1);
  assign accept = cfg_valid & cfg_ready;
  assign ch_ok  = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt    <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      led_out   <= IDLE;
    end else begin
      ps_cnt    <= tick ? '0 : ps_cnt + 1'b1;
      cfg_ready <= 1'b1;
      cfg_err   <= accept & ~ch_ok;
      led_out   <= lit ^ IDLE;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pattern_chan #(.CNT_W(CNT_W)) u_chan (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .wr          (accept & (cfg_ch == CH_W'(i))),
      .wr_mode     (mode_t'(cfg_mode)),
      .wr_period   (cfg_period),
      .wr_duty     (cfg_duty),
      .lit         (lit[i]),
      .period_tick (period_tick[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench comparing the LED generator against a tick-count model.
module tb_led_pattern_gen;
  localparam int NCH = 6;
  localparam int CW  = 26;
  localparam int PS  = 3;
  localparam bit AL  = 1'b1;

  typedef struct {
    logic [NCH-1:0] led;
    logic [NCH-1:0] pt;
    logic           err;
    logic           rdy;
  } exp_t;

  logic           sys_clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic [CW-1:0]  cfg_duty = '0;
  logic           cfg_err;
  logic [NCH-1:0] period_tick;
  logic [NCH-1:0] led_out;

  led_pattern_gen #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(PS), .ACTIVE_LOW(AL)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_err     (cfg_err),
    .period_tick (period_tick),
    .led_out     (led_out)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  // model: each channel is described by its config and the number of ticks since it was loaded
  int          c;
  int          m_mode[NCH];
  int          m_per[NCH];
  int          m_duty[NCH];
  longint      m_k[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic longint eff(input int i);
    return (m_per[i] == 0) ? 1 : longint'(m_per[i]);
  endfunction

  function automatic bit lit(input int i);
    case (m_mode[i])
      1: return 1'b1;
      2: return ((m_k[i] / eff(i)) % 2) == 1;
      3: return (m_k[i] % eff(i)) < longint'(m_duty[i]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.led = {NCH{AL}};
    e.pt  = '0;
    e.err = 1'b0;
    e.rdy = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0;
      m_per[i]  = 1;
      m_duty[i] = 0;
      m_k[i]    = 0;
    end
    c = 0;
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("led_out", 32'(led_out), 32'(e.led));
        chk("period_tick", 32'(period_tick), 32'(e.pt));
        chk("cfg_err", 32'(cfg_err), 32'(e.err));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      end
    end
  end

  // consume one clock edge: predict the outputs of the following cycle from the inputs just sampled
  task automatic step();
    exp_t e;
    bit   tick, acc, wr;
    @(posedge sys_clk);
    tick = (c % PS) == PS - 1;
    acc  = cfg_valid && (c >= 1);
    for (int i = 0; i < NCH; i++) begin
      wr = acc && (int'(cfg_ch) == i);
      e.led[i] = lit(i) ^ AL;
      e.pt[i]  = tick && !wr && ((m_k[i] % eff(i)) == eff(i) - 1);
      if (wr) begin
        m_mode[i] = int'(cfg_mode);
        m_per[i]  = int'(cfg_period);
        m_duty[i] = int'(cfg_duty);
        m_k[i]    = 0;
      end else if (tick) m_k[i]++;
    end
    e.err = acc && (int'(cfg_ch) >= NCH);
    e.rdy = 1'b1;
    exp_q.push_back(e);
    c++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int md, input int p, input int d);
    cfg_valid  = 1'b1;
    cfg_ch     = 3'(ch);
    cfg_mode   = 2'(md);
    cfg_period = CW'(p);
    cfg_duty   = CW'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_led_out", 32'(led_out), 32'({NCH{AL}}));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
    chk("rst_period_tick", 32'(period_tick), 32'(0));
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_hold_cfg_ready", 32'(cfg_ready), 32'(0));
    rst_n = 1'b1;
    model_reset();
    exp_q.push_back(reset_exp());
    mon_en = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    repeat (n) begin
      if ($urandom_range(0, 5) == 0)
        wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 9),
           ($urandom_range(0, 15) == 0) ? 26'h3ffffff : $urandom_range(0, 11));
      else idle(1);
    end
  endtask

  initial begin
    #2;
    do_reset();
    idle(2);
    wr(0, 2, 4, 0);
    idle(30);
    wr(1, 3, 5, 2);
    idle(45);
    wr(1, 3, 5, 0);
    idle(20);
    wr(1, 3, 5, 7);
    idle(20);
    wr(7, 1, 3, 3);
    idle(3);
    wr(6, 3, 2, 1);
    idle(3);
    wr(2, 2, 0, 0);
    idle(10);
    wr(2, 1, 6, 0);
    idle(6);
    rand_phase(800);
    wr(3, 3, 8, 3);
    idle(14);
    #2;
    do_reset();
    idle(12);
    rand_phase(400);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
